// File: rtl/pic_inta_sequencer.sv
// Interrupt-acknowledge sequencer for an 8259-style PIC: drives INT, counts the two
// 8086-mode INTA pulses, presents the vector byte and issues the automatic-EOI strobe.
module pic_inta_sequencer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       int_req,
  input  logic [2:0] isr_level,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  output logic       int_out,
  output logic [1:0] inta_count,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       aeoi_pulse
);

  typedef enum logic [2:0] {StIdle, StReq, StAck1, StAck2, StHold} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   inta_s, inta_d_q;
  logic                   fall, rise;
  logic [7:0]             vec_q, vec_d;
  logic                   rise_seen_q, rise_seen_d;

  assign inta_s = sync_q[SYNC_STAGES-1];
  assign fall   = inta_d_q & ~inta_s;
  assign rise   = ~inta_d_q & inta_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= '1;
      inta_d_q    <= 1'b1;
      state_q     <= StIdle;
      vec_q       <= '0;
      rise_seen_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], inta_n};
      inta_d_q    <= inta_s;
      state_q     <= state_d;
      vec_q       <= vec_d;
      rise_seen_q <= rise_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    rise_seen_d = rise_seen_q;
    unique case (state_q)
      StIdle: begin
        if (int_req) state_d = StReq;
      end
      StReq: begin
        if (fall) begin
          state_d     = StAck1;
          rise_seen_d = 1'b0;
        end
      end
      StAck1: begin
        // The vector is only latched on a fall that follows the end of the first pulse.
        if (rise) rise_seen_d = 1'b1;
        if (fall && rise_seen_q) begin
          vec_d   = {vector_base, isr_level};
          state_d = StAck2;
        end
      end
      StAck2: begin
        if (rise) state_d = StHold;
      end
      StHold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    int_out    = 1'b0;
    inta_count = 2'b00;
    data_oe    = 1'b0;
    aeoi_pulse = 1'b0;
    unique case (state_q)
      StReq: begin
        int_out = 1'b1;
      end
      StAck1: begin
        inta_count = 2'b01;
      end
      StAck2: begin
        inta_count = 2'b10;
        data_oe    = 1'b1;
      end
      StHold: begin
        inta_count = 2'b10;
        aeoi_pulse = aeoi;
      end
      default: begin
      end
    endcase
  end

  assign data_out = vec_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Scoreboard bench for pic_inta_sequencer: the stimulus pushes expected vector deliveries,
// a negedge monitor pops and checks them whenever the DUT drives the bus.
module tb_pic_inta_sequencer;

  logic       clk;
  logic       rst_n;
  logic       int_req;
  logic [2:0] isr_level;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       int_out;
  logic [1:0] inta_count;
  logic [7:0] data_out;
  logic       data_oe;
  logic       aeoi_pulse;

  pic_inta_sequencer #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .int_req    (int_req),
    .isr_level  (isr_level),
    .inta_n     (inta_n),
    .vector_base(vector_base),
    .aeoi       (aeoi),
    .int_out    (int_out),
    .inta_count (inta_count),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .aeoi_pulse (aeoi_pulse)
  );

  typedef struct {
    logic [7:0] vec;
    logic       ae;
    int         t_on;
    int         t_off;
    bit         abort;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_vec();
    vector_base = 5'($urandom);
    isr_level   = 3'($urandom);
  endtask

  task automatic request();
    chk("int_out_idle", int_out, 0);
    int_req = 1'b1;
    tick();
    chk("int_out_rise", int_out, 1);
  endtask

  // Drives both INTA pulses; the DUT is expected to be waiting in the request phase.
  task automatic ack_seq(input logic [4:0] vb, input logic [2:0] lvl, input logic ae,
                         input int lo1, input int hi1, input int lo2, input int hi2,
                         input bit keep_req, input bit abort);
    exp_t e;
    inta_n = 1'b0;
    for (int i = 1; i <= lo1; i++) begin
      tick();
      if (!keep_req) int_req = 1'b0;
      scramble_vec();
      aeoi = 1'($urandom);
      if (i == 2) chk("int_out_hold", int_out, 1);
      if (i == 3) begin
        chk("int_out_drop", int_out, 0);
        chk("count_ack1", inta_count, 1);
      end
    end
    inta_n = 1'b1;
    for (int i = 1; i <= hi1; i++) begin
      tick();
      scramble_vec();
    end
    inta_n      = 1'b0;
    vector_base = vb;
    isr_level   = lvl;
    e.vec   = 8'(int'(vb) * 8 + int'(lvl));
    e.ae    = ae;
    e.t_on  = cyc + 3;
    e.t_off = cyc + lo2 + 3;
    e.abort = abort;
    sb.push_back(e);
    if (abort) begin
      for (int i = 0; i < 10 && data_oe !== 1'b1; i++) tick();
      chk("abort_oe_seen", data_oe, 1);
      rst_n   = 1'b0;
      inta_n  = 1'b1;
      int_req = 1'b0;
      tick();
      chk("rst_data_oe", data_oe, 0);
      chk("rst_count", inta_count, 0);
      chk("rst_int_out", int_out, 0);
      rst_n   = 1'b1;
      int_req = 1'b1;
      tick();
      chk("req_after_rst", int_out, 1);
      return;
    end
    for (int i = 1; i <= lo2; i++) begin
      tick();
      if (i >= 4) scramble_vec();
      aeoi = 1'($urandom);
    end
    inta_n = 1'b1;
    aeoi   = ae;
    for (int i = 1; i <= hi2; i++) begin
      tick();
      if (i >= 5) begin
        scramble_vec();
        aeoi = 1'($urandom);
      end
      if (keep_req && i == 4) chk("b2b_idle", int_out, 0);
      if (keep_req && i == 5) chk("b2b_rereq", int_out, 1);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT starts driving the bus.
  initial begin
    exp_t cur;
    bit   have, pend, fall_evt;
    logic oe_prev;
    have    = 0;
    pend    = 0;
    oe_prev = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      fall_evt = 0;
      if (pend) begin
        chk("aeoi_width", aeoi_pulse, 0);
        chk("count_idle", inta_count, 0);
        pend = 0;
      end
      if (data_oe === 1'b1 && oe_prev !== 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_oe", data_oe, 0);
        end else begin
          cur  = sb.pop_front();
          have = 1;
          chk("vector", data_out, cur.vec);
          chk("t_oe_on", cyc, cur.t_on);
          chk("count_ack2", inta_count, 2);
        end
      end else if (data_oe !== 1'b1 && oe_prev === 1'b1 && have) begin
        have     = 0;
        fall_evt = 1;
        if (cur.abort) begin
          chk("abort_count", inta_count, 0);
          chk("abort_int_out", int_out, 0);
          chk("abort_data", data_out, 0);
          chk("abort_aeoi", aeoi_pulse, 0);
        end else begin
          chk("t_oe_off", cyc, cur.t_off);
          chk("aeoi_hold", aeoi_pulse, cur.ae);
          chk("count_hold", inta_count, 2);
          chk("vector_held", data_out, cur.vec);
          pend = 1;
        end
      end
      if (aeoi_pulse === 1'b1 && !fall_evt) chk("stray_aeoi", aeoi_pulse, 0);
      oe_prev = data_oe;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bit prev_keep;
    rst_n       = 1'b0;
    int_req     = 1'b0;
    inta_n      = 1'b1;
    vector_base = '0;
    isr_level   = '0;
    aeoi        = 1'b0;
    repeat (3) tick();
    chk("rst_int_out0", int_out, 0);
    chk("rst_count0", inta_count, 0);
    chk("rst_data0", data_out, 0);
    chk("rst_oe0", data_oe, 0);
    chk("rst_aeoi0", aeoi_pulse, 0);
    mon_en = 1;
    rst_n  = 1'b1;
    tick();

    // Basic sequence and AEOI variant: vector 8'h43.
    request();
    ack_seq(5'b01000, 3'd3, 1'b0, 6, 6, 6, 8, 0, 0);
    request();
    ack_seq(5'b01000, 3'd3, 1'b1, 6, 6, 6, 8, 0, 0);

    // Spurious: one-cycle request, interrupt block reports level 7.
    int_req = 1'b1;
    tick();
    chk("spur_int_out", int_out, 1);
    int_req = 1'b0;
    repeat (5) tick();
    chk("spur_latched", int_out, 1);
    ack_seq(5'b11111, 3'd7, 1'b0, 6, 6, 6, 8, 0, 0);

    // Stray INTA while idle.
    bad     = 0;
    int_req = 1'b0;
    inta_n  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) inta_n = 1'b1;
      tick();
      if (int_out !== 1'b0 || data_oe !== 1'b0 || inta_count !== 2'b00) bad++;
    end
    repeat (4) tick();
    chk("stray_inta", bad, 0);

    // Reset while the vector is on the bus, then finish a clean sequence.
    request();
    ack_seq(5'b00101, 3'd6, 1'b1, 6, 6, 6, 8, 0, 1);
    ack_seq(5'b00101, 3'd1, 1'b1, 6, 6, 6, 8, 0, 0);

    // Back-to-back with int_req held high; second run carries a new level.
    request();
    ack_seq(5'b10010, 3'd5, 1'b0, 6, 6, 6, 8, 1, 0);
    ack_seq(5'b10010, 3'd2, 1'b1, 6, 6, 6, 8, 0, 0);

    // Randomized sequences.
    prev_keep = 0;
    for (int n = 0; n < 20; n++) begin
      logic [4:0] vb;
      logic [2:0] lvl;
      bit         keep;
      vb   = 5'($urandom);
      lvl  = ($urandom_range(3, 0) == 0) ? 3'd7 : 3'($urandom);
      keep = (n != 19) && ($urandom_range(1, 0) == 1);
      if (!prev_keep) request();
      ack_seq(vb, lvl, 1'($urandom), $urandom_range(9, 4), $urandom_range(9, 4),
              $urandom_range(9, 4), $urandom_range(9, 6), keep, 0);
      prev_keep = keep;
    end

    repeat (6) tick();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_inta_sequencer.md
# pic_inta_sequencer

Interrupt-acknowledge sequencer for the 8259-style PIC. It sits directly downstream of the interrupt block: it takes that block's pending-interrupt flag and in-service level and drives the CPU INT pin. It samples the CPU's active-low INTA strobe through a synchronizer and counts the two 8086-mode acknowledge pulses, producing the intAcounter code the interrupt block consumes. On the second pulse it drives the vector {ICW2[7:3], level} onto the data bus and issues the automatic-EOI strobe.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop depth of the inta_n synchronizer (≥2).

Ports:
- clk  in  1  single block clock; every register updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- int_req  in  1  pending-interrupt flag from the interrupt block (INTtocontrol).
- isr_level  in  3  in-service level from the interrupt block (ISRtocontrol).
- inta_n  in  1  CPU acknowledge strobe; asynchronous, active-low.
- vector_base  in  5  ICW2 bits T7..T3.
- aeoi  in  1  automatic-EOI mode enable.
- int_out  out  1  interrupt request to the CPU.
- inta_count  out  2  acknowledge phase to the interrupt block: 00 idle, 01 after first pulse, 10 after second pulse.
- data_out  out  8  vector byte.
- data_oe  out  1  data bus drive enable.
- aeoi_pulse  out  1  one-cycle automatic-EOI strobe.

## Operation
- inta_n passes through SYNC_STAGES flops into inta_s. A registered copy inta_d gives:
  - fall = inta_d & ~inta_s
  - rise = ~inta_d & inta_s
- States: IDLE, REQ, ACK1, ACK2, HOLD.
- IDLE: int_out=0, inta_count=00. If int_req=1, go to REQ. fall and rise are ignored here; no bus drive.
- REQ: int_out=1. int_out stays latched even if int_req drops. On fall, go to ACK1.
- ACK1 (first pulse): int_out=0, inta_count=01. Wait for rise, then for the next fall. On that second fall, latch vec = {vector_base, isr_level} and go to ACK2.
- ACK2: inta_count=10, data_oe=1, data_out=vec. On rise, go to HOLD with data_oe=0.
- HOLD: a single cycle with inta_count=10. aeoi_pulse=aeoi in this cycle. Then go to IDLE; inta_count returns to 00.
- Spurious case: if int_req has fallen by the time of the second fall, the interrupt block reports level 7. The sequencer passes isr_level through unchanged, giving vector {vector_base,3'b111}. It does not qualify the level itself.
- A new int_req during ACK1, ACK2 or HOLD is not served until the return to IDLE. From IDLE, REQ is re-entered on the next cycle if int_req is still 1.
- vector_base and aeoi are sampled only at the second fall (vector) and in HOLD (aeoi). Changes at other times have no effect on the cycle in progress.
- Reset mid-sequence, in any state: on the next clk edge with rst_n=0, the block returns to IDLE and all outputs take their reset values. The synchronizer flops and inta_d reset to 1.

## Timing
- Reset values: int_out=0, inta_count=00, data_out=8'h00, data_oe=0, aeoi_pulse=0, state=IDLE.
- int_req high → int_out=1 one cycle later.
- Detection latency: an inta_n edge is seen as fall/rise SYNC_STAGES+1 cycles after it; the state changes on that same edge. This gives 3 cycles at the default depth.
- int_out drops, and inta_count=01, in the cycle after the first fall.
- data_oe=1 and valid data_out appear in the cycle after the second fall. data_oe returns to 0 in the cycle after the second rise.
- aeoi_pulse is exactly 1 cycle wide, the cycle after data_oe deasserts. data_out holds vec until the next latch.
- CPU requirement: each inta_n low or high phase lasts at least SYNC_STAGES+2 clk periods. Shorter glitches may be missed. They must never produce a partial vector.

## Test plan
- Basic sequence: reset, vector_base=5'b01000, int_req=1, isr_level=3, aeoi=0, then two INTA pulses of 6 cycles each.
  - Expected: int_out rises 1 cycle after int_req and falls 3 cycles after the first inta_n fall.
  - inta_count goes 00→01→10→00.
  - data_oe high from 3 cycles after the second fall until 3 cycles after the second rise, with data_out=8'h43.
  - aeoi_pulse stays 0.
- AEOI: same sequence with aeoi=1 → a single 1-cycle aeoi_pulse in HOLD, and inta_count=00 one cycle later.
- Spurious: int_req pulses for 1 cycle, then the block sees isr_level=7 and vector_base=5'b11111 → int_out held until the first INTA, data_out=8'hFF on the second pulse.
- Stray INTA in IDLE: inta_n pulses with int_req=0 → int_out, data_oe and inta_count stay 0/0/00 throughout.
- Reset in ACK2 (data_oe=1), rst_n=0 for one cycle → next cycle data_oe=0, inta_count=00, int_out=0. After rst_n returns to 1 with int_req=1, int_out=1 one cycle later.
- Back-to-back: int_req held at 1 through the whole sequence → int_out re-asserts 2 cycles after the second rise is detected (HOLD, then IDLE→REQ). The second sequence delivers the newly presented isr_level.
